// File: rtl/cpu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_seq_ctrl
// Eight-phase instruction sequencer for the 8-bit accumulator CPU. A phase
// counter steps through fetch (phases 0-3) and execute (phases 4-7). The
// datapath strobes are decoded combinationally from the registered phase,
// the IR opcode and the ALU zero flag.
//
// Optional build macro: SEQ_CTRL_STALL_EN
//   Adds input mem_ready. In phases 1, 5 and 7 the phase holds while
//   mem_ready=0, and the strobes keep their values. Without the macro the
//   port does not exist and the sequencer never stalls.
// ---------------------------------------------------------------------------
module cpu_seq_ctrl #(
  parameter logic [2:0] RST_PHASE = 3'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] opcode,
  input  logic       zero,
`ifdef SEQ_CTRL_STALL_EN
  input  logic       mem_ready,
`endif
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       inc_pc,
  output logic       ld_pc,
  output logic       ld_ac,
  output logic       data_e,
  output logic       wr,
  output logic       halt,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    PH_INST_ADDR  = 3'd0,
    PH_INST_FETCH = 3'd1,
    PH_INST_LOAD  = 3'd2,
    PH_IDLE       = 3'd3,
    PH_OP_ADDR    = 3'd4,
    PH_OP_FETCH   = 3'd5,
    PH_ALU_OP     = 3'd6,
    PH_STORE      = 3'd7
  } phase_e;

  typedef enum logic [2:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } opcode_e;

  phase_e  phase_q, phase_d;
  logic    halted_q, halted_d;
  logic    stall;
  logic    alu_op;
  opcode_e op;

  assign op     = opcode_e'(opcode);
  assign alu_op = (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  assign phase  = phase_q;

`ifdef SEQ_CTRL_STALL_EN
  // Memory-access phases wait for the memory to accept the cycle.
  assign stall = !mem_ready &&
                 ((phase_q == PH_INST_FETCH) || (phase_q == PH_OP_FETCH) ||
                  (phase_q == PH_STORE));
`else
  assign stall = 1'b0;
`endif

  // Phase and halted-flag state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block evaluation order.
    if (!rst_n) begin
      phase_q  <= phase_e'(RST_PHASE);
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

  // Next phase: halt freezes the counter at OP_ADDR; a stall holds it;
  // otherwise advance with natural 7 -> 0 wrap.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    phase_d  = phase_q;
    halted_d = halted_q;
    if (!halted_q) begin
      if (phase_q == PH_OP_ADDR && op == OP_HLT) begin
        halted_d = 1'b1;
      end else if (!stall) begin
        phase_d = phase_e'(phase_q + 3'd1);
      end
    end
  end

  // Strobe decode from the registered phase, opcode and zero flag.
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    data_e = 1'b0;
    wr     = 1'b0;
    halt   = 1'b0;
    if (!rst_n) begin
      // Reset values hold regardless of RST_PHASE while reset is asserted.
      sel = 1'b1;
    end else if (halted_q) begin
      halt = 1'b1;
    end else begin
      case (phase_q)
        PH_INST_ADDR: begin
          sel = 1'b1;
        end
        PH_INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        PH_INST_LOAD, PH_IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        PH_OP_ADDR: begin
          inc_pc = 1'b1;
          halt   = (op == OP_HLT);
        end
        PH_OP_FETCH: begin
          rd = alu_op;
        end
        PH_ALU_OP: begin
          rd     = alu_op;
          inc_pc = (op == OP_SKZ) && zero;
          ld_pc  = (op == OP_JMP);
          data_e = (op == OP_STO);
        end
        PH_STORE: begin
          rd     = alu_op;
          ld_ac  = alu_op;
          ld_pc  = (op == OP_JMP);
          data_e = (op == OP_STO);
          wr     = (op == OP_STO);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpu_seq_ctrl
// Directed bench for cpu_seq_ctrl: a table of per-cycle vectors covering
// whole instructions, plus hand-written halt, reset and stall sequences.
// ---------------------------------------------------------------------------
module tb_cpu_seq_ctrl;

  // Strobe bit positions in the packed comparison word.
  localparam logic [8:0] S_SEL  = 9'h100;
  localparam logic [8:0] S_RD   = 9'h080;
  localparam logic [8:0] S_LDIR = 9'h040;
  localparam logic [8:0] S_INC  = 9'h020;
  localparam logic [8:0] S_LDPC = 9'h010;
  localparam logic [8:0] S_LDAC = 9'h008;
  localparam logic [8:0] S_DE   = 9'h004;
  localparam logic [8:0] S_WR   = 9'h002;
  localparam logic [8:0] S_HALT = 9'h001;
  localparam logic [8:0] S_NONE = 9'h000;

  localparam logic [2:0] HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, AND_ = 3'd3;
  localparam logic [2:0] XOR_ = 3'd4, LDA = 3'd5, STO = 3'd6, JMP = 3'd7;

  typedef struct {
    logic [2:0] op;
    logic       z;
    logic [2:0] ph;
    logic [8:0] st;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [2:0] opcode;
  logic       zero;
`ifdef SEQ_CTRL_STALL_EN
  logic       mem_ready;
`endif
  logic sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, halt;
  logic [2:0] phase;

  int checks   = 0;
  int failures = 0;
  vec_t vecs[$];

  cpu_seq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .opcode    (opcode),
    .zero      (zero),
`ifdef SEQ_CTRL_STALL_EN
    .mem_ready (mem_ready),
`endif
    .sel       (sel),
    .rd        (rd),
    .ld_ir     (ld_ir),
    .inc_pc    (inc_pc),
    .ld_pc     (ld_pc),
    .ld_ac     (ld_ac),
    .data_e    (data_e),
    .wr        (wr),
    .halt      (halt),
    .phase     (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] strobes();
    return {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, halt};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Push one full instruction: fetch phases are fixed, execute phases given.
  // jop is the opcode shown during fetch, which must not affect outputs.
  task automatic add_instr(input logic [2:0] op, input logic z, input logic [2:0] jop,
                           input logic [8:0] e4, input logic [8:0] e5,
                           input logic [8:0] e6, input logic [8:0] e7);
    vecs.push_back('{jop, z, 3'd0, S_SEL});
    vecs.push_back('{jop, z, 3'd1, S_SEL | S_RD});
    vecs.push_back('{jop, z, 3'd2, S_SEL | S_RD | S_LDIR});
    vecs.push_back('{op,  z, 3'd3, S_SEL | S_RD | S_LDIR});
    vecs.push_back('{op,  z, 3'd4, e4});
    vecs.push_back('{op,  z, 3'd5, e5});
    vecs.push_back('{op,  z, 3'd6, e6});
    vecs.push_back('{op,  z, 3'd7, e7});
  endtask

  // Drive inputs just after a posedge, check mid-cycle, advance one clock.
  task automatic apply(input vec_t v, input string tag);
    opcode = v.op;
    zero   = v.z;
    #2;
    check({tag, "_phase"}, 32'(phase), 32'(v.ph));
    check({tag, "_strobes"}, 32'(strobes()), 32'(v.st));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n  = 1'b0;
    opcode = HLT;
    zero   = 1'b0;
`ifdef SEQ_CTRL_STALL_EN
    mem_ready = 1'b1;
`endif

    // Vector table.
    add_instr(ADD,  1'b0, ADD, S_INC, S_RD, S_RD, S_RD | S_LDAC);
    add_instr(STO,  1'b0, STO, S_INC, S_NONE, S_DE, S_DE | S_WR);
    add_instr(SKZ,  1'b1, SKZ, S_INC, S_NONE, S_INC, S_NONE);
    add_instr(SKZ,  1'b0, SKZ, S_INC, S_NONE, S_NONE, S_NONE);
    add_instr(JMP,  1'b0, JMP, S_INC, S_NONE, S_LDPC, S_LDPC);
    add_instr(XOR_, 1'b1, HLT, S_INC, S_RD, S_RD, S_RD | S_LDAC);
    add_instr(AND_, 1'b0, JMP, S_INC, S_RD, S_RD, S_RD | S_LDAC);
    add_instr(LDA,  1'b1, STO, S_INC, S_RD, S_RD, S_RD | S_LDAC);

    // Reset state.
    repeat (2) @(posedge clk);
    #2;
    check("reset_phase", 32'(phase), 32'd0);
    check("reset_strobes", 32'(strobes()), 32'(S_SEL));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Table-driven instruction sequences.
    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

`ifdef SEQ_CTRL_STALL_EN
    // Stalled store: wr held for four cycles, then wrap to phase 0.
    for (int p = 0; p < 7; p++) apply(vecs[8 + p], $sformatf("stall_pre%0d", p));
    mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) apply('{STO, 1'b0, 3'd7, S_DE | S_WR}, $sformatf("stall_hold%0d", k));
    mem_ready = 1'b1;
    apply('{STO, 1'b0, 3'd7, S_DE | S_WR}, "stall_last");
    apply('{STO, 1'b0, 3'd0, S_SEL}, "stall_wrap");
    for (int p = 1; p < 8; p++) apply(vecs[8 + p], $sformatf("stall_post%0d", p));
`endif

    // Halt: fetch a HLT, freeze at phase 4 with only halt asserted.
    apply('{HLT, 1'b0, 3'd0, S_SEL}, "hlt_p0");
    apply('{HLT, 1'b0, 3'd1, S_SEL | S_RD}, "hlt_p1");
    apply('{HLT, 1'b0, 3'd2, S_SEL | S_RD | S_LDIR}, "hlt_p2");
    apply('{HLT, 1'b0, 3'd3, S_SEL | S_RD | S_LDIR}, "hlt_p3");
    apply('{HLT, 1'b0, 3'd4, S_INC | S_HALT}, "hlt_p4");
    for (int k = 0; k < 10; k++) apply('{HLT, 1'b0, 3'd4, S_HALT}, $sformatf("halted%0d", k));
    for (int k = 0; k < 12; k++) apply('{JMP, 1'b1, 3'd4, S_HALT}, $sformatf("halted_jmp%0d", k));

    // Reset pulse clears the halted flag asynchronously.
    rst_n = 1'b0;
    #1;
    check("hlt_rst_phase", 32'(phase), 32'd0);
    check("hlt_rst_strobes", 32'(strobes()), 32'(S_SEL));
    #2;
    rst_n = 1'b1;
    #2;
    apply('{ADD, 1'b0, 3'd0, S_SEL}, "post_hlt_p0");
    apply('{ADD, 1'b0, 3'd1, S_SEL | S_RD}, "post_hlt_p1");

    // Mid-instruction reset in phase 5 aborts at once.
    for (int p = 2; p < 5; p++) apply(vecs[8 + p], $sformatf("abort_pre%0d", p));
    opcode = STO;
    #2;
    check("abort_p5_phase", 32'(phase), 32'd5);
    rst_n = 1'b0;
    #1;
    check("abort_rst_phase", 32'(phase), 32'd0);
    check("abort_rst_strobes", 32'(strobes()), 32'(S_SEL));
    @(posedge clk);
    #2;
    check("abort_rst_hold_phase", 32'(phase), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    apply('{ADD, 1'b0, 3'd1, S_SEL | S_RD}, "abort_restart_p1");
    apply('{ADD, 1'b0, 3'd2, S_SEL | S_RD | S_LDIR}, "abort_restart_p2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_seq_ctrl.md
Name: cpu_seq_ctrl

Overview:
- Eight-phase instruction sequencer for the 8-bit accumulator CPU.
- Steps a phase counter through fetch/execute and decodes the 3-bit opcode (from IR) plus the ALU zero flag into datapath strobes: address mux, memory read/write, IR/ACC/PC loads, PC increment, data bus enable, halt.
- Sits between IR, ALU is_zero, PC, ACC and the memory interface; the single control point of the datapath.

Parameters:
- RST_PHASE, 3'd0, phase entered on reset (INST_ADDR); kept at 0 for normal builds.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  3  IR[7:5]; HLT=0 SKZ=1 ADD=2 AND=3 XOR=4 LDA=5 STO=6 JMP=7
- zero  in  1  ALU is_zero (ACC==0)
- sel  out  1  1: memory address from PC; 0: from IR operand
- rd  out  1  memory read enable
- ld_ir  out  1  load IR from data bus
- inc_pc  out  1  PC increment
- ld_pc  out  1  load PC from IR operand
- ld_ac  out  1  load ACC from ALU out
- data_e  out  1  drive ALU out onto data bus
- wr  out  1  memory write strobe
- halt  out  1  CPU halted
- phase  out  3  current phase (debug)

Behaviour:
- Reset: clk with asynchronous active-low reset rst_n. While rst_n=0: phase=RST_PHASE, halted flag=0, sel=1, every other strobe 0.
- Phase register advances by +1 each clk, wrapping 7->0. Phases: 0 INST_ADDR, 1 INST_FETCH, 2 INST_LOAD, 3 IDLE, 4 OP_ADDR, 5 OP_FETCH, 6 ALU_OP, 7 STORE.
- Strobes are combinational from the registered phase, opcode and zero (zero-cycle decode latency). ALUOP = opcode in {ADD, AND, XOR, LDA}.
- Phase 0: sel=1.
- Phase 1: sel=1, rd=1.
- Phase 2: sel=1, rd=1, ld_ir=1.
- Phase 3: sel=1, rd=1, ld_ir=1.
- Phase 4: inc_pc=1; halt=1 if opcode==HLT.
- Phase 5: rd=ALUOP.
- Phase 6: rd=ALUOP; inc_pc=(opcode==SKZ && zero); ld_pc=(opcode==JMP); data_e=(opcode==STO).
- Phase 7: rd=ALUOP; ld_ac=ALUOP; ld_pc=(opcode==JMP); data_e=(opcode==STO); wr=(opcode==STO).
- All strobes not listed for a phase are 0.
- opcode is sampled only in phases 4-7. It must be stable from the end of phase 3 onward; values in phases 0-3 do not affect outputs.
- zero is used only in phase 6.
- Halt:
  - On the clk edge that ends phase 4 with opcode==HLT, the halted flag sets and phase freezes at 4.
  - While halted: halt=1 and all other strobes 0. The PC does not re-increment.
  - Only rst_n clears the halted flag.
- SKZ with zero=1 causes a second PC increment in the same instruction, skipping the next instruction. SKZ with zero=0 is a no-op.
- Reset asserted mid-instruction aborts immediately. Strobes fall to the reset values asynchronously. Fetch restarts at phase 0 on the first edge after rst_n rises.

Optional Feature:
- Macro SEQ_CTRL_STALL_EN adds input mem_ready (1 bit).
- With the macro: in phases 1, 5 and 7, if mem_ready=0 the phase holds and strobes keep their values (stalled write keeps wr=1). Phase advances on the edge where mem_ready=1. Other phases ignore mem_ready. Reset and halt have priority over stall.
- Without the macro: no port; the sequencer never stalls.

Test Plan:
- Reset release, opcode=ADD, zero=0 -> phase 0..7 in successive cycles; sel=1 only in phases 0-3; ld_ir=1 in phases 2-3; ld_ac=1 in phase 7 only; wr never asserts; wraps to phase 0.
- opcode=STO -> data_e=1 in phases 6-7, wr=1 only in phase 7, rd=0 in phases 5-7, ld_ac=0.
- opcode=SKZ: zero=1 -> inc_pc=1 in phases 4 and 6 (2 pulses); zero=0 -> inc_pc=1 in phase 4 only.
- opcode=JMP -> ld_pc=1 in phases 6-7, inc_pc=1 in phase 4 only.
- opcode=HLT -> halt=1 from phase 4, phase stays 4 for 20+ cycles with all other strobes 0; rst_n pulse low -> phase=0, halt=0, sel=1.
- SEQ_CTRL_STALL_EN defined, opcode=STO, mem_ready=0 for 3 cycles in phase 7 -> phase holds 7 and wr=1 for 4 cycles, then phase 0. Assert rst_n=0 mid-phase 5 -> outputs return to the reset values immediately.
